// File: rtl/condicionador_botoes.sv
// Push-button conditioner: two-flop sync, per-button debounce FSM, gated one-shot
// press strobes and a saturating count of accepted press cycles (jogadas).
//
// state       | meaning
// ------------+-------------------------------------------------------------
// SOLTO       | button released and stable; waiting for a high sample
// CONF_PRESS  | high seen, counting consecutive highs before accepting press
// PRESSIONADO | button pressed and stable; waiting for a low sample
// CONF_SOLTA  | low seen, counting consecutive lows before accepting release

module condicionador_botoes #(
    parameter int N_BOTOES        = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int JOGADAS_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BOTOES-1:0]  botoes_raw,
    input  logic                 habilitar,
    input  logic                 limpar_jogadas,
    output logic [N_BOTOES-1:0]  botoes_pulso,
    output logic                 botao_valido,
    output logic [JOGADAS_W-1:0] jogadas,
    output logic [N_BOTOES-1:0]  db_estavel
);

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONF_PRESS  = 2'd1,
        PRESSIONADO = 2'd2,
        CONF_SOLTA  = 2'd3
    } estado_t;

    localparam logic [CNT_W-1:0]     CNT_ULT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_UM  = CNT_W'(1);
    localparam logic [JOGADAS_W-1:0] JOG_MAX = {JOGADAS_W{1'b1}};
    localparam logic [JOGADAS_W-1:0] JOG_UM  = JOGADAS_W'(1);

    logic [N_BOTOES-1:0]  r_sync1;
    logic [N_BOTOES-1:0]  r_sync2;
    logic [N_BOTOES-1:0]  w_entra_press;
    logic [N_BOTOES-1:0]  w_pulso_prox;
    logic [N_BOTOES-1:0]  r_pulso;
    logic                 r_valido;
    logic [JOGADAS_W-1:0] r_jogadas;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= botoes_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_BOTOES; g++) begin : g_botao
        estado_t          r_estado;
        logic [CNT_W-1:0] r_cnt;
        logic             r_db;

        // Same condition the FSM uses to move CONF_PRESS -> PRESSIONADO.
        assign w_entra_press[g] = (r_estado == CONF_PRESS) && r_sync2[g] && (r_cnt == CNT_ULT);
        assign db_estavel[g]    = r_db;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_estado <= SOLTO;
                r_cnt    <= '0;
                r_db     <= 1'b0;
            end else begin
                case (r_estado)
                    SOLTO: begin
                        if (r_sync2[g]) begin
                            r_estado <= CONF_PRESS;
                            r_cnt    <= CNT_UM;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    CONF_PRESS: begin
                        if (!r_sync2[g]) begin
                            r_estado <= SOLTO;
                            r_cnt    <= '0;
                        end else if (r_cnt == CNT_ULT) begin
                            r_estado <= PRESSIONADO;
                            r_cnt    <= '0;
                            r_db     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_UM;
                        end
                    end
                    PRESSIONADO: begin
                        if (!r_sync2[g]) begin
                            r_estado <= CONF_SOLTA;
                            r_cnt    <= CNT_UM;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    CONF_SOLTA: begin
                        if (r_sync2[g]) begin
                            r_estado <= PRESSIONADO;
                            r_cnt    <= '0;
                        end else if (r_cnt == CNT_ULT) begin
                            r_estado <= SOLTO;
                            r_cnt    <= '0;
                            r_db     <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_UM;
                        end
                    end
                    default: begin
                        r_estado <= SOLTO;
                        r_cnt    <= '0;
                        r_db     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // habilitar is sampled only on the acceptance edge, so a gated press is lost for good.
    assign w_pulso_prox = w_entra_press & {N_BOTOES{habilitar}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulso   <= '0;
            r_valido  <= 1'b0;
            r_jogadas <= '0;
        end else begin
            r_pulso  <= w_pulso_prox;
            r_valido <= |w_pulso_prox;
            if (limpar_jogadas) begin
                r_jogadas <= '0;
            end else if (r_valido && (r_jogadas != JOG_MAX)) begin
                r_jogadas <= r_jogadas + JOG_UM;
            end
        end
    end

    assign botoes_pulso = r_pulso;
    assign botao_valido = r_valido;
    assign jogadas      = r_jogadas;

endmodule
